// File: rtl/lq_ptr_alloc.sv
// Load-queue pointer allocator: circular {flipped, idx} head/tail pointers with
// multi-slot allocate, multi-slot retire and squash rollback of the tail.
module lq_ptr_alloc #(
  parameter int SIZE         = 64,
  parameter int ALLOC_WIDTH  = 4,
  parameter int COMMIT_WIDTH = 4,
  parameter int PW           = $clog2(SIZE) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ALLOC_WIDTH-1:0]    i_alloc_req,
  output logic                      o_can_alloc,
  output logic [ALLOC_WIDTH*PW-1:0] o_alloc_idx,
  input  logic [COMMIT_WIDTH-1:0]   i_commit_vld,
  input  logic                      i_squash,
  input  logic [PW-1:0]             i_squash_idx,
  output logic [PW-1:0]             o_head,
  output logic [PW-1:0]             o_tail,
  output logic [PW-1:0]             o_count,
  output logic                      o_empty,
  output logic                      o_full
);

  localparam logic [PW-1:0] SIZE_P = PW'(SIZE);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] alloc_cnt;
  logic [PW-1:0] commit_cnt;
  logic [PW-1:0] count;
  logic [PW-1:0] free_cnt;
  logic          alloc_fire;

  always_comb begin
    alloc_cnt = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_cnt = alloc_cnt + PW'(i_alloc_req[i]);
    end
  end

  always_comb begin
    commit_cnt = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      commit_cnt = commit_cnt + PW'(i_commit_vld[i]);
    end
  end

  // Modulo-2^PW difference: the flipped bit disambiguates full from empty.
  assign count    = tail_q - head_q;
  assign free_cnt = SIZE_P - count;

  assign o_can_alloc = (free_cnt >= alloc_cnt);
  assign alloc_fire  = (|i_alloc_req) && o_can_alloc && !i_squash;

  always_comb begin
    head_d = head_q + commit_cnt;
    tail_d = tail_q;
    if (i_squash) begin
      tail_d = i_squash_idx;
    end else if (alloc_fire) begin
      tail_d = tail_q + alloc_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  for (genvar g = 0; g < ALLOC_WIDTH; g++) begin : g_alloc_idx
    assign o_alloc_idx[g*PW +: PW] = tail_q + PW'(g);
  end

  assign o_head  = head_q;
  assign o_tail  = tail_q;
  assign o_count = count;
  assign o_empty = (head_q == tail_q);
  assign o_full  = (head_q[PW-2:0] == tail_q[PW-2:0]) && (head_q[PW-1] != tail_q[PW-1]);

`ifndef SYNTHESIS
  logic [ALLOC_WIDTH-1:0]  req_p1;
  logic [COMMIT_WIDTH-1:0] cmt_p1;
  logic [PW-1:0]           sq_off;
  logic [PW-1:0]           sq_lim;

  // A vector is contiguous from bit 0 exactly when v & (v+1) == 0.
  assign req_p1 = i_alloc_req + ALLOC_WIDTH'(1);
  assign cmt_p1 = i_commit_vld + COMMIT_WIDTH'(1);
  assign sq_off = i_squash_idx - head_d;
  assign sq_lim = tail_q - head_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((i_alloc_req & req_p1) == '0)
        else $error("lq_ptr_alloc: non-contiguous alloc request %b", i_alloc_req);
      assert ((i_commit_vld & cmt_p1) == '0)
        else $error("lq_ptr_alloc: non-contiguous commit vector %b", i_commit_vld);
      assert (commit_cnt <= count)
        else $error("lq_ptr_alloc: commit %0d exceeds count %0d", commit_cnt, count);
      assert (!i_squash || (sq_off <= sq_lim))
        else $error("lq_ptr_alloc: squash idx %0h outside [%0h,%0h]", i_squash_idx, head_d, tail_q);
      assert (count <= SIZE_P)
        else $error("lq_ptr_alloc: count %0d exceeds size", count);
    end
  end
`endif

endmodule

// File: tb/tb_lq_ptr_alloc.sv
// Scoreboard bench for lq_ptr_alloc: an absolute-sequence-number model predicts
// outputs per cycle; a negedge monitor pops and compares them.
module tb_lq_ptr_alloc;
  localparam int SIZE = 64;
  localparam int AW   = 4;
  localparam int CW   = 4;
  localparam int PW   = 7;
  localparam int MODV = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   i_alloc_req;
  logic            o_can_alloc;
  logic [AW*PW-1:0] o_alloc_idx;
  logic [CW-1:0]   i_commit_vld;
  logic            i_squash;
  logic [PW-1:0]   i_squash_idx;
  logic [PW-1:0]   o_head, o_tail, o_count;
  logic            o_empty, o_full;

  lq_ptr_alloc #(.SIZE(SIZE), .ALLOC_WIDTH(AW), .COMMIT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .i_alloc_req(i_alloc_req), .o_can_alloc(o_can_alloc), .o_alloc_idx(o_alloc_idx),
    .i_commit_vld(i_commit_vld), .i_squash(i_squash), .i_squash_idx(i_squash_idx),
    .o_head(o_head), .o_tail(o_tail), .o_count(o_count),
    .o_empty(o_empty), .o_full(o_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int head, tail, count, empty, full, can;
    int idx[AW];
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model: unbounded sequence numbers; the DUT pointer is the number mod 2^PW.
  int m_head = 0;
  int m_tail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int na, input int nc, input bit sq, input int sq_abs, input bit r);
    exp_t e;
    int   cnt;
    rst          = r;
    i_alloc_req  = AW'((1 << na) - 1);
    i_commit_vld = CW'((1 << nc) - 1);
    i_squash     = sq;
    i_squash_idx = PW'(sq_abs % MODV);
    cnt     = m_tail - m_head;
    e.head  = m_head % MODV;
    e.tail  = m_tail % MODV;
    e.count = cnt;
    e.empty = (cnt == 0);
    e.full  = (cnt == SIZE);
    e.can   = ((SIZE - cnt) >= na);
    for (int i = 0; i < AW; i++) e.idx[i] = (m_tail + i) % MODV;
    exp_q.push_back(e);
    @(posedge clk);
    if (r) begin
      m_head = 0;
      m_tail = 0;
    end else begin
      m_head = m_head + nc;
      if (sq) m_tail = sq_abs;
      else if (na > 0 && (SIZE - cnt) >= na) m_tail = m_tail + na;
    end
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("head", int'(o_head), e.head);
        chk("tail", int'(o_tail), e.tail);
        chk("count", int'(o_count), e.count);
        chk("empty", int'(o_empty), e.empty);
        chk("full", int'(o_full), e.full);
        chk("can_alloc", int'(o_can_alloc), e.can);
        for (int i = 0; i < AW; i++)
          chk($sformatf("alloc_idx%0d", i), int'(o_alloc_idx[i*PW +: PW]), e.idx[i]);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cnt, na, nc, k;
    bit sq, r;
    rst = 1'b1; i_alloc_req = '0; i_commit_vld = '0; i_squash = 1'b0; i_squash_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0);
    chk("rst_empty", int'(o_empty), 1);
    chk("rst_can", int'(o_can_alloc), 1);

    // Fill to full, then a single request must stall.
    repeat (16) step(4, 0, 0, 0, 0);
    chk("fill_tail", int'(o_tail), 'h40);
    chk("fill_count", int'(o_count), 64);
    chk("fill_full", int'(o_full), 1);
    step(1, 0, 0, 0, 0);
    chk("full_stall_tail", int'(o_tail), 'h40);

    // Commit at full with a simultaneous request: freed space only visible next cycle.
    step(4, 3, 0, 0, 0);
    chk("cf_head", int'(o_head), 3);
    chk("cf_count", int'(o_count), 61);
    i_alloc_req = 4'b0111; #1;
    chk("cf_can3", int'(o_can_alloc), 1);
    i_alloc_req = 4'b1111; #1;
    chk("cf_can4", int'(o_can_alloc), 0);

    // Wrap: empty queue parked at idx 62.
    step(0, 0, 0, 0, 1);
    repeat (15) step(4, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0);
    repeat (15) step(0, 4, 0, 0, 0);
    step(0, 2, 0, 0, 0);
    i_alloc_req = 4'b1111; #1;
    chk("wrap_idx2", int'(o_alloc_idx[2*PW +: PW]), 'h40);
    chk("wrap_idx3", int'(o_alloc_idx[3*PW +: PW]), 'h41);
    step(4, 0, 0, 0, 0);
    chk("wrap_tail", int'(o_tail), 'h42);
    chk("wrap_count", int'(o_count), 4);

    // Squash with concurrent commit and dropped allocation.
    step(0, 0, 0, 0, 1);
    repeat (7) step(4, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0);
    repeat (2) step(0, 4, 0, 0, 0);
    step(0, 2, 0, 0, 0);
    step(4, 2, 1, 20, 0);
    chk("sq_tail", int'(o_tail), 20);
    chk("sq_head", int'(o_head), 12);
    chk("sq_count", int'(o_count), 8);

    // Reset wins over everything with the queue half full.
    step(0, 0, 0, 0, 1);
    repeat (8) step(4, 0, 0, 0, 0);
    step(4, 2, 1, 10, 1);
    chk("rst_mid_head", int'(o_head), 0);
    chk("rst_mid_tail", int'(o_tail), 0);
    chk("rst_mid_empty", int'(o_empty), 1);

    // Random legal traffic.
    for (int c = 0; c < 3000; c++) begin
      cnt = m_tail - m_head;
      na  = $urandom_range(0, 4);
      nc  = $urandom_range(0, (cnt < 4) ? cnt : 4);
      sq  = ($urandom_range(0, 7) == 0);
      k   = $urandom_range(0, cnt - nc);
      r   = ($urandom_range(0, 199) == 0);
      step(na, nc, sq, m_head + nc + k, r);
    end

    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) chk("queue_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lq_ptr_alloc.md
Name: lq_ptr_alloc

Overview:
- Circular-pointer allocator for the load queue, `LQSIZE` entries.
- Sits at dispatch, between rename/dispatch and LQ entry storage.
- Hands out up to ALLOC_WIDTH {flipped, idx} load-queue indices per cycle and retires up to COMMIT_WIDTH entries per cycle from the head.
- Rolls the tail back on a pipeline squash.

Parameters:
SIZE, `LQSIZE` (64), queue depth; must be a power of two, ≥ ALLOC_WIDTH
ALLOC_WIDTH, 4, allocation slots per cycle
COMMIT_WIDTH, 4, retire slots per cycle
PW, $clog2(SIZE)+1, pointer width (flipped bit + idx)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
i_alloc_req  in  ALLOC_WIDTH  per-slot allocate request; set bits contiguous from slot 0
o_can_alloc  out  1  free entries ≥ popcount(i_alloc_req)
o_alloc_idx  out  ALLOC_WIDTH×PW  index for slot i, as lqIdx_t
i_commit_vld  in  COMMIT_WIDTH  per-slot retire; contiguous from slot 0
i_squash  in  1  squash; discard entries from i_squash_idx to tail
i_squash_idx  in  PW  oldest entry to discard, as lqIdx_t
o_head  out  PW  oldest valid entry pointer
o_tail  out  PW  next entry to allocate
o_count  out  PW  occupied entries, 0..SIZE
o_empty  out  1  o_count == 0
o_full  out  1  o_count == SIZE

Behaviour:
- State: head_q and tail_q, both PW-bit registers. All outputs derive from these two registers and the current inputs.
- Reset: head_q = tail_q = 0 (flipped = 0, idx = 0). This gives o_head = o_tail = 0, o_count = 0, o_empty = 1, o_full = 0, o_can_alloc = 1.
- Reset has priority over every other input. Reset in mid-operation empties the queue in one cycle.
- Pointer arithmetic is plain PW-bit unsigned addition, modulo 2^PW. Carry out of the idx field toggles the flipped bit. No explicit wrap logic is needed because SIZE is a power of two.
- o_count = tail_q − head_q (PW-bit modulo).
  - o_full: head.idx == tail.idx and flipped bits differ.
  - o_empty: head_q == tail_q.
- o_alloc_idx[i] = tail_q + i for every slot, combinational, regardless of the request bits.
- o_can_alloc = (SIZE − o_count) ≥ popcount(i_alloc_req).
  - Combinational from the registers and i_alloc_req only.
  - Does not credit entries committed in the same cycle.
- Allocation fires when |i_alloc_req && o_can_alloc && !i_squash. Next tail_q = tail_q + popcount(i_alloc_req).
- Allocation is all-or-nothing. If o_can_alloc = 0, no slot allocates and dispatch stalls.
- Commit: head_q ← head_q + popcount(i_commit_vld) every cycle.
  - Applies even when i_squash = 1, since committed loads are older than any squash point.
  - Legal only when popcount ≤ o_count.
- Squash: tail_q ← i_squash_idx. Any allocation in the same cycle is dropped.
  - i_squash_idx must lie in [head_q + commits, tail_q], compared with OLDER_THAN semantics.
  - i_squash_idx == tail_q is a legal no-op.
  - i_squash_idx == new head empties the queue.
- Simultaneous alloc and commit at full:
  - o_can_alloc = 0 in that cycle.
  - Commit frees entries; allocation succeeds the following cycle.
- Latency: every pointer update is visible on outputs the cycle after the triggering edge.
- Assertions, simulation only:
  - Non-contiguous request or commit vector.
  - Commit exceeding o_count.
  - i_squash_idx outside the legal range.
  - o_count > SIZE.

Test Plan:
- Reset, then idle 3 cycles → head = tail = 0, o_count = 0, o_empty = 1, o_can_alloc = 1; o_alloc_idx = {0,1,2,3} with flipped = 0.
- 16 cycles of i_alloc_req = 4'b1111, no commit:
  - After cycle 16: tail = {1,0}, o_count = 64, o_full = 1.
  - Cycle 17 request 4'b0001 → o_can_alloc = 0, tail unchanged.
- From full, commit 4'b0111 with request 4'b1111:
  - That cycle: no allocation.
  - Next cycle: head = {0,3}, o_count = 61, o_can_alloc = 1 for 3 requests, 0 for 4.
- Wrap: head = tail = {0,62}, alloc 4'b1111 → o_alloc_idx = {0,62},{0,63},{1,0},{1,1}; next tail = {1,2}, o_count = 4.
- Squash with alloc, head = {0,10}, tail = {0,30}:
  - Stimulus: i_squash = 1, i_squash_idx = {0,20}, commit 4'b0011, alloc 4'b1111.
  - Response: tail = {0,20}, head = {0,12}, o_count = 8, no allocation.
- Reset asserted with alloc, commit and squash all active, queue half full → next cycle head = tail = 0, o_empty = 1.
